varint_stream_enc: RTL and testbench

Streaming protobuf varint encoder. It accepts one 64-bit scalar plus its 5-bit protobuf field type per input handshake. It applies the type-dependent pre-transform (zigzag32, zigzag64, sign-extension or zero-extension) and emits the varint bytes over a valid/ready byte stream, OUT_BYTES lanes per beat. It sits between the field scheduler and the message byte packer, and replaces the fixed 80-bit parallel varint output with a backpressure-aware, width-configurable stream.

---
 rtl/varint_stream_enc.sv | 144 ++++++++++++++
 tb/tb_varint_stream_enc.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/varint_stream_enc.sv
// Protobuf varint encoder: type pre-transform, then OUT_BYTES-lane valid/ready byte stream; `VARINT_STATS_EN adds counters.
// First beat one cycle after accept, back-to-back without bubbles; outputs hold while out_ready is low.
module varint_stream_enc #(
  parameter int OUT_BYTES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [63:0]            in_value,
  input  logic [4:0]             in_field_type,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*OUT_BYTES-1:0] out_data,
  output logic [OUT_BYTES-1:0]   out_keep,
  output logic                   out_last
`ifdef VARINT_STATS_EN
  ,
  output logic [31:0]            stat_values,
  output logic [31:0]            stat_bytes
`endif
);

  localparam int MAX_BYTES = 10;

  if (OUT_BYTES < 1 || OUT_BYTES > MAX_BYTES) begin : g_bad_out_bytes
    $error("varint_stream_enc: OUT_BYTES must be in 1..10");
  end

  typedef enum logic {IDLE, EMIT} state_e;

  state_e                 state_q, state_d;
  logic [63:0]            v_q, v_d;
  logic [3:0]             nbytes_q, nbytes_d;
  logic [3:0]             beat_q, beat_d;
  logic [63:0]            xf_value;
  logic [3:0]             xf_len;
  logic [8*MAX_BYTES-1:0] enc_flat;
  logic                   last_beat;
  logic                   accept;

  always_comb begin
    case (in_field_type)
      5'd17:        xf_value = {32'd0, {in_value[30:0], 1'b0} ^ {32{in_value[31]}}};
      5'd18:        xf_value = {in_value[62:0], 1'b0} ^ {64{in_value[63]}};
      5'd5, 5'd14:  xf_value = {{32{in_value[31]}}, in_value[31:0]};
      5'd13:        xf_value = {32'd0, in_value[31:0]};
      default:      xf_value = in_value;
    endcase
    xf_len = 4'd1;
    for (int i = 1; i < MAX_BYTES; i++) begin
      if ((xf_value >> (7 * i)) != 64'd0) xf_len = 4'(i + 1);
    end
  end

  // Byte 9 only ever carries v[63]; the continuation bit is set on every byte but the final one.
  always_comb begin
    enc_flat = '0;
    for (int i = 0; i < MAX_BYTES - 1; i++) begin
      enc_flat[8*i +: 8] = {(4'(i) < (nbytes_q - 4'd1)), v_q[7*i +: 7]};
    end
    enc_flat[8*(MAX_BYTES-1) +: 8] = {7'd0, v_q[63]};
  end

  always_comb begin
    out_valid = (state_q == EMIT);
    last_beat = ((int'(beat_q) + 1) * OUT_BYTES) >= int'(nbytes_q);
    out_last  = out_valid & last_beat;
    out_data  = '0;
    out_keep  = '0;
    for (int j = 0; j < OUT_BYTES; j++) begin
      if (out_valid && (int'(beat_q) * OUT_BYTES + j) < int'(nbytes_q)) begin
        out_data[8*j +: 8] = 8'(enc_flat >> (8 * (int'(beat_q) * OUT_BYTES + j)));
        out_keep[j]        = 1'b1;
      end
    end
    in_ready = (state_q == IDLE) | (out_valid & out_ready & out_last);
    accept   = in_valid & in_ready;
  end

  always_comb begin
    state_d  = state_q;
    v_d      = v_q;
    nbytes_d = nbytes_q;
    beat_d   = beat_q;
    if (accept) begin
      state_d  = EMIT;
      v_d      = xf_value;
      nbytes_d = xf_len;
      beat_d   = 4'd0;
    end else if (out_valid && out_ready) begin
      if (out_last) begin
        state_d = IDLE;
        beat_d  = 4'd0;
      end else begin
        beat_d  = beat_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      v_q      <= '0;
      nbytes_q <= 4'd1;
      beat_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      v_q      <= v_d;
      nbytes_q <= nbytes_d;
      beat_q   <= beat_d;
    end
  end

`ifdef VARINT_STATS_EN
  logic [31:0] stat_values_q, stat_values_d;
  logic [31:0] stat_bytes_q, stat_bytes_d;
  logic [32:0] bytes_sum;

  always_comb begin
    stat_values_d = stat_values_q;
    stat_bytes_d  = stat_bytes_q;
    bytes_sum     = {1'b0, stat_bytes_q} + 33'(xf_len);
    if (accept) begin
      if (stat_values_q != 32'hFFFF_FFFF) stat_values_d = stat_values_q + 32'd1;
      stat_bytes_d = bytes_sum[32] ? 32'hFFFF_FFFF : bytes_sum[31:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_values_q <= '0;
      stat_bytes_q  <= '0;
    end else begin
      stat_values_q <= stat_values_d;
      stat_bytes_q  <= stat_bytes_d;
    end
  end

  assign stat_values = stat_values_q;
  assign stat_bytes  = stat_bytes_q;
`endif

endmodule

// File: tb/tb_varint_stream_enc.sv
// Scoreboard bench: a 1-lane and a 4-lane encoder, directed values with hand-computed varint bytes.
module tb_varint_stream_enc;

  typedef struct {
    logic [79:0] data;
    logic [9:0]  keep;
    logic        last;
    int          acc;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst1, rst4;
  logic        in_valid1, in_valid4;
  logic        in_ready1, in_ready4;
  logic [63:0] in_value;
  logic [4:0]  in_ft;
  logic        out_valid1, out_valid4;
  logic        out_ready1, out_ready4;
  logic [7:0]  out_data1;
  logic [31:0] out_data4;
  logic [0:0]  out_keep1;
  logic [3:0]  out_keep4;
  logic        out_last1, out_last4;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc, acc2;
  bit          tog1 = 1'b0;

  beat_t       q1[$];
  beat_t       q4[$];
  bit          stalled[2];
  bit          lat_done[2];
  logic [79:0] pd[2];
  logic [9:0]  pk[2];
  logic        pl[2];
  int          hs_last[2];

  varint_stream_enc #(.OUT_BYTES(1)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_value(in_value), .in_field_type(in_ft),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_keep(out_keep1), .out_last(out_last1)
  );

  varint_stream_enc #(.OUT_BYTES(4)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_value(in_value), .in_field_type(in_ft),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .out_keep(out_keep4), .out_last(out_last4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tog1) out_ready1 = ~out_ready1;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic push(input int w, input logic [79:0] bytes, input int n, input int a);
    int    ob;
    int    nb;
    beat_t b;
    ob = (w == 0) ? 1 : 4;
    nb = (n + ob - 1) / ob;
    for (int k = 0; k < nb; k++) begin
      b.data = '0;
      b.keep = '0;
      b.last = (k == nb - 1);
      b.acc  = (k == 0) ? a : -1;
      for (int j = 0; j < ob; j++) begin
        if (k * ob + j < n) begin
          b.data[8*j +: 8] = bytes[8*(k*ob+j) +: 8];
          b.keep[j]        = 1'b1;
        end
      end
      if (w == 0) q1.push_back(b);
      else        q4.push_back(b);
    end
  endtask

  task automatic send(input int w, input logic [63:0] val, input logic [4:0] ft,
                      input logic [79:0] bytes, input int n, output int a);
    bit ok;
    ok = 1'b0;
    a  = -1;
    @(negedge clk);
    in_value = val;
    in_ft    = ft;
    if (w == 0) in_valid1 = 1'b1;
    else        in_valid4 = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      #1;
      if ((w == 0) ? in_ready1 : in_ready4) begin
        @(posedge clk);
        #1;
        a = cyc;
        push(w, bytes, n, cyc);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    in_valid1 = 1'b0;
    in_valid4 = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout lane%0d: value %h not accepted, required acceptance within 200 cycles", w, val);
    end
  endtask

  task automatic drain(input int w);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 500 && !done; t++) begin
      @(negedge clk);
      #3;
      if (w == 0) done = (q1.size() == 0) && !out_valid1;
      else        done = (q4.size() == 0) && !out_valid4;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain%0d: got %0d beats outstanding, required 0", w, (w == 0) ? q1.size() : q4.size());
    end
  endtask

  task automatic mon_step(input int w, input logic rs, input logic v, input logic r, input logic l,
                          input logic [79:0] d, input logic [9:0] k);
    beat_t h;
    bit    have;
    if (rs) begin
      stalled[w]  = 1'b0;
      lat_done[w] = 1'b0;
      return;
    end
    if (stalled[w]) begin
      checks++;
      if (v !== 1'b1 || d !== pd[w] || k !== pk[w] || l !== pl[w]) begin
        errors++;
        $display("FAIL stall_hold%0d: got v=%b d=%h k=%b l=%b, required v=1 d=%h k=%b l=%b",
                 w, v, d, k, l, pd[w], pk[w], pl[w]);
      end
    end
    have = (w == 0) ? (q1.size() > 0) : (q4.size() > 0);
    if (have) h = (w == 0) ? q1[0] : q4[0];
    if (v && have && h.acc >= 0 && !lat_done[w]) begin
      checks++;
      lat_done[w] = 1'b1;
      if (cyc != h.acc) begin
        errors++;
        $display("FAIL first_beat_latency%0d: got cycle %0d, required cycle %0d", w, cyc, h.acc);
      end
    end
    if (v && r) begin
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL unexpected_beat%0d: got d=%h k=%b l=%b, required no beat", w, d, k, l);
      end else begin
        if (d !== h.data || k !== h.keep || l !== h.last) begin
          errors++;
          $display("FAIL beat%0d: got d=%h k=%b l=%b, required d=%h k=%b l=%b",
                   w, d, k, l, h.data, h.keep, h.last);
        end
        if (w == 0) void'(q1.pop_front());
        else        void'(q4.pop_front());
        lat_done[w] = 1'b0;
      end
      if (l) hs_last[w] = cyc + 1;
    end
    stalled[w] = v && !r;
    pd[w] = d;
    pk[w] = k;
    pl[w] = l;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      mon_step(0, rst1, out_valid1, out_ready1, out_last1, 80'(out_data1), 10'(out_keep1));
      mon_step(1, rst4, out_valid4, out_ready4, out_last4, 80'(out_data4), 10'(out_keep4));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst1 = 1'b1; rst4 = 1'b1;
    in_valid1 = 1'b1; in_valid4 = 1'b1;
    in_value = 64'd7; in_ft = 5'd4;
    out_ready1 = 1'b1; out_ready4 = 1'b1;
    #3;
    chk("rst_out_valid1", 80'(out_valid1), 80'd0);
    chk("rst_out_data1",  80'(out_data1),  80'd0);
    chk("rst_out_keep1",  80'(out_keep1),  80'd0);
    chk("rst_out_last1",  80'(out_last1),  80'd0);
    chk("rst_in_ready1",  80'(in_ready1),  80'd1);
    chk("rst_out_valid4", 80'(out_valid4), 80'd0);
    chk("rst_out_data4",  80'(out_data4),  80'd0);
    chk("rst_in_ready4",  80'(in_ready4),  80'd1);
    @(negedge clk);
    @(negedge clk);
    in_valid1 = 1'b0; in_valid4 = 1'b0;
    rst1 = 1'b0; rst4 = 1'b0;
    #1;
    chk("post_rst_out_valid1", 80'(out_valid1), 80'd0);

    send(0, 64'd300, 5'd4, 80'h02AC, 2, acc);
    send(0, 64'd0, 5'd4, 80'h00, 1, acc);
    send(0, 64'hFFFF_FFFF_FFFF_FFFE, 5'd18, 80'h03, 1, acc);
    send(0, 64'h7FFF_FFFF, 5'd17, 80'h0F_FFFF_FFFE, 5, acc);
    send(0, 64'hFFFF_FFFF, 5'd5, 80'h01_FFFF_FFFF_FFFF_FFFF_FF, 10, acc);
    send(0, 64'hFFFF_FFFF_0000_0080, 5'd13, 80'h0180, 2, acc);
    send(0, 64'h1_0000_0005, 5'd14, 80'h05, 1, acc);
    drain(0);

    tog1 = 1'b1;
    send(0, 64'd1, 5'd4, 80'h01, 1, acc);
    send(0, 64'd2, 5'd4, 80'h02, 1, acc2);
    chk("b2b_accept_on_last_hs", 80'(acc2), 80'(hs_last[0]));
    send(0, 64'd300, 5'd4, 80'h02AC, 2, acc);
    drain(0);
    tog1 = 1'b0;
    @(negedge clk);
    #1;
    out_ready1 = 1'b1;
    @(negedge clk);

    send(0, 64'hFFFF_FFFF, 5'd5, 80'h01_FFFF_FFFF_FFFF_FFFF_FF, 10, acc);
    @(negedge clk);
    @(negedge clk);
    chk("mid_beat2_valid", 80'(out_valid1), 80'd1);
    chk("mid_beat2_data",  80'(out_data1),  80'hFF);
    rst1 = 1'b1;
    #1;
    chk("async_rst_valid", 80'(out_valid1), 80'd0);
    chk("async_rst_data",  80'(out_data1),  80'd0);
    chk("async_rst_keep",  80'(out_keep1),  80'd0);
    chk("async_rst_last",  80'(out_last1),  80'd0);
    q1.delete();
    @(negedge clk);
    rst1 = 1'b0;
    #1;
    chk("post_rst_in_ready1", 80'(in_ready1), 80'd1);
    chk("post_rst_valid1",    80'(out_valid1), 80'd0);
    send(0, 64'd5, 5'd4, 80'h05, 1, acc);
    drain(0);

    send(1, 64'h8000_0000_0000_0000, 5'd4, 80'h01_8080_8080_8080_8080_80, 10, acc);
    send(1, 64'd300, 5'd4, 80'h02AC, 2, acc);
    send(1, 64'h7FFF_FFFF, 5'd17, 80'h0F_FFFF_FFFE, 5, acc);
    drain(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
